// File: rtl/kernel_ctrl_s_axi_n.sv
// AXI4-Lite control slave for kernel family: ap_ctrl block, interrupts,
// parametrised 32-bit scalar and 64-bit pointer arguments.
module kernel_ctrl_s_axi_n #(
    parameter int C_ADDR_WIDTH  = 12,
    parameter int C_DATA_WIDTH  = 32,
    parameter int C_NUM_SCALARS = 1,
    parameter int C_NUM_PTRS    = 2
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        aclk_en,
    input  logic                        awvalid,
    output logic                        awready,
    input  logic [C_ADDR_WIDTH-1:0]     awaddr,
    input  logic                        wvalid,
    output logic                        wready,
    input  logic [C_DATA_WIDTH-1:0]     wdata,
    input  logic [C_DATA_WIDTH/8-1:0]   wstrb,
    output logic                        bvalid,
    input  logic                        bready,
    output logic [1:0]                  bresp,
    input  logic                        arvalid,
    output logic                        arready,
    input  logic [C_ADDR_WIDTH-1:0]     araddr,
    output logic                        rvalid,
    input  logic                        rready,
    output logic [C_DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                  rresp,
    output logic                        interrupt,
    output logic                        ap_start,
    input  logic                        ap_idle,
    input  logic                        ap_done,
    input  logic                        ap_ready,
    output logic [32*C_NUM_SCALARS-1:0] scalars,
    output logic [64*C_NUM_PTRS-1:0]    ptrs
);

    localparam int AW = C_ADDR_WIDTH;
    localparam logic [AW-1:0] A_CTRL = AW'(32'h00);
    localparam logic [AW-1:0] A_GIE  = AW'(32'h04);
    localparam logic [AW-1:0] A_IER  = AW'(32'h08);
    localparam logic [AW-1:0] A_ISR  = AW'(32'h0C);

    typedef enum logic [1:0] {WRRESET, WRIDLE, WRDATA, WRRESP} wstate_e;
    typedef enum logic [1:0] {RDRESET, RDIDLE, RDDATA} rstate_e;

    wstate_e wstate_q;
    rstate_e rstate_q;
    logic [AW-1:0] waddr_q;
    logic [C_DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic start_q, start_d;
    logic done_q, done_d;
    logic ready_q, ready_d;
    logic auto_q, gie_q;
    logic [1:0] ier_q, isr_q, isr_d;

    // Pointer words: [j][0] is the low word, [j][1] the high word.
    logic [C_NUM_SCALARS-1:0][31:0]   scal_q;
    logic [C_NUM_PTRS-1:0][1:0][31:0] ptr_q;

    logic wr_fire, rd_fire, rd_ctrl;
    logic wr_ctrl, wr_gie, wr_ier, wr_isr;

    function automatic logic [AW-1:0] sc_addr(input int i);
        return AW'(16 + 8 * i);
    endfunction

    function automatic logic [AW-1:0] pt_addr(input int j, input int h);
        return AW'(16 + 8 * C_NUM_SCALARS + 8 * j + 4 * h);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o,
                                          input logic [31:0] d,
                                          input logic [3:0]  s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    assign awready   = (wstate_q == WRIDLE);
    assign wready    = (wstate_q == WRDATA);
    assign bvalid    = (wstate_q == WRRESP);
    assign bresp     = 2'b00;
    assign arready   = (rstate_q == RDIDLE);
    assign rvalid    = (rstate_q == RDDATA);
    assign rresp     = 2'b00;
    assign rdata     = rdata_q;
    assign ap_start  = start_q;
    assign interrupt = gie_q & (|isr_q);
    assign scalars   = scal_q;
    assign ptrs      = ptr_q;

    assign wr_fire = aclk_en && (wstate_q == WRDATA) && wvalid;
    assign rd_fire = aclk_en && (rstate_q == RDIDLE) && arvalid;
    assign rd_ctrl = rd_fire && (araddr == A_CTRL);
    assign wr_ctrl = wr_fire && wstrb[0] && (waddr_q == A_CTRL);
    assign wr_gie  = wr_fire && wstrb[0] && (waddr_q == A_GIE);
    assign wr_ier  = wr_fire && wstrb[0] && (waddr_q == A_IER);
    assign wr_isr  = wr_fire && wstrb[0] && (waddr_q == A_ISR);

    // Later assignments take priority: sets win over clears/toggles.
    always_comb begin
        start_d = start_q;
        if (ap_ready) start_d = 1'b0;
        if (auto_q && ap_done) start_d = 1'b1;
        if (wr_ctrl && wdata[0]) start_d = 1'b1;

        done_d = done_q;
        if (rd_ctrl) done_d = 1'b0;
        if (ap_done) done_d = 1'b1;

        ready_d = ready_q;
        if (rd_ctrl) ready_d = 1'b0;
        if (ap_ready) ready_d = 1'b1;

        isr_d = isr_q;
        if (wr_isr) isr_d = isr_q ^ wdata[1:0];
        if (ap_done && ier_q[0]) isr_d[0] = 1'b1;
        if (ap_ready && ier_q[1]) isr_d[1] = 1'b1;
    end

    always_comb begin
        rdata_d = '0;
        if (araddr == A_CTRL) begin
            rdata_d[0] = start_q;
            rdata_d[1] = done_q;
            rdata_d[2] = ap_idle;
            rdata_d[3] = ready_q;
            rdata_d[7] = auto_q;
        end
        if (araddr == A_GIE) rdata_d[0] = gie_q;
        if (araddr == A_IER) rdata_d[1:0] = ier_q;
        if (araddr == A_ISR) rdata_d[1:0] = isr_q;
        for (int i = 0; i < C_NUM_SCALARS; i++)
            if (araddr == sc_addr(i)) rdata_d = scal_q[i];
        for (int j = 0; j < C_NUM_PTRS; j++)
            for (int h = 0; h < 2; h++)
                if (araddr == pt_addr(j, h)) rdata_d = ptr_q[j][h];
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wstate_q <= WRRESET;
            waddr_q  <= '0;
        end else if (aclk_en) begin
            unique case (wstate_q)
                WRRESET: wstate_q <= WRIDLE;
                WRIDLE: if (awvalid) begin
                    waddr_q  <= awaddr;
                    wstate_q <= WRDATA;
                end
                WRDATA: if (wvalid) wstate_q <= WRRESP;
                WRRESP: if (bready) wstate_q <= WRIDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            rstate_q <= RDRESET;
            rdata_q  <= '0;
        end else if (aclk_en) begin
            unique case (rstate_q)
                RDRESET: rstate_q <= RDIDLE;
                RDIDLE: if (arvalid) begin
                    rdata_q  <= rdata_d;
                    rstate_q <= RDDATA;
                end
                RDDATA: if (rready) rstate_q <= RDIDLE;
                default: rstate_q <= RDRESET;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            auto_q  <= 1'b0;
            gie_q   <= 1'b0;
            ier_q   <= '0;
            isr_q   <= '0;
        end else if (aclk_en) begin
            start_q <= start_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            isr_q   <= isr_d;
            if (wr_ctrl) auto_q <= wdata[7];
            if (wr_gie) gie_q <= wdata[0];
            if (wr_ier) ier_q <= wdata[1:0];
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            scal_q <= '0;
            ptr_q  <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < C_NUM_SCALARS; i++)
                if (waddr_q == sc_addr(i))
                    scal_q[i] <= merge(scal_q[i], wdata, wstrb);
            for (int j = 0; j < C_NUM_PTRS; j++)
                for (int h = 0; h < 2; h++)
                    if (waddr_q == pt_addr(j, h))
                        ptr_q[j][h] <= merge(ptr_q[j][h], wdata, wstrb);
        end
    end

endmodule

// File: tb/tb_kernel_ctrl_s_axi_n.sv
// Directed bench for kernel_ctrl_s_axi_n with two scalars and two pointers.
module tb_kernel_ctrl_s_axi_n;

    logic         aclk = 1'b0;
    logic         areset, aclk_en;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [11:0]  awaddr, araddr;
    logic [31:0]  wdata, rdata;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic         interrupt, ap_start, ap_idle, ap_done, ap_ready;
    logic [63:0]  scalars;
    logic [127:0] ptrs;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] rv;

    kernel_ctrl_s_axi_n #(
        .C_ADDR_WIDTH(12), .C_DATA_WIDTH(32),
        .C_NUM_SCALARS(2), .C_NUM_PTRS(2)
    ) dut (
        .aclk(aclk), .areset(areset), .aclk_en(aclk_en),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .interrupt(interrupt), .ap_start(ap_start), .ap_idle(ap_idle),
        .ap_done(ap_done), .ap_ready(ap_ready),
        .scalars(scalars), .ptrs(ptrs)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d,
                      input logic [3:0] s);
        int t;
        awvalid = 1'b1;
        awaddr  = a;
        t = 0;
        while (!awready && t < 20) begin step(); t++; end
        chk("awready", awready, 1);
        step();
        awvalid = 1'b0;
        wvalid  = 1'b1;
        wdata   = d;
        wstrb   = s;
        t = 0;
        while (!wready && t < 20) begin step(); t++; end
        step();
        wvalid = 1'b0;
        bready = 1'b1;
        t = 0;
        while (!bvalid && t < 20) begin step(); t++; end
        chk("bvalid", bvalid, 1);
        step();
        bready = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d);
        int t;
        arvalid = 1'b1;
        araddr  = a;
        t = 0;
        while (!arready && t < 20) begin step(); t++; end
        step();
        arvalid = 1'b0;
        rready  = 1'b1;
        t = 0;
        while (!rvalid && t < 20) begin step(); t++; end
        chk("rvalid", rvalid, 1);
        d = rdata;
        step();
        rready = 1'b0;
    endtask

    task automatic pulse_ready();
        ap_ready = 1'b1;
        step();
        ap_ready = 1'b0;
    endtask

    task automatic pulse_done();
        ap_done = 1'b1;
        step();
        ap_done = 1'b0;
    endtask

    initial begin
        areset = 1'b1; aclk_en = 1'b1;
        awvalid = 0; awaddr = 0; wvalid = 0; wdata = 0; wstrb = 0;
        bready = 0; arvalid = 0; araddr = 0; rready = 0;
        ap_idle = 0; ap_done = 0; ap_ready = 0;
        repeat (3) step();
        chk("rst_awready", awready, 0);
        chk("rst_arready", arready, 0);
        areset = 1'b0;
        chk("post_rst_awready", awready, 0);
        chk("post_rst_arready", arready, 0);
        chk("rst_outputs", {ap_start, interrupt, bvalid, rvalid}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_scalars", scalars, 0);
        chk("rst_ptrs", ptrs[127:64], 0);
        chk("rst_ptrs_lo", ptrs[63:0], 0);
        step();
        chk("idle_awready", awready, 1);
        chk("idle_arready", arready, 1);

        ap_idle = 1'b1;
        rd(12'h000, rv); chk("ctrl_idle", rv, 32'h4);

        wr(12'h018, 32'hDEADBEEF, 4'hF);
        chk("scalar1", scalars[63:32], 32'hDEADBEEF);
        wr(12'h02C, 32'h1, 4'hF);
        chk("ptr1_hi", ptrs[127:96], 32'h1);
        wr(12'h014, 32'h12345678, 4'hF);
        chk("reserved_wr", scalars, 64'hDEADBEEF_00000000);
        rd(12'h014, rv); chk("reserved_rd", rv, 0);
        rd(12'h018, rv); chk("scalar1_rd", rv, 32'hDEADBEEF);

        wr(12'h020, 32'h11223344, 4'hF);
        wr(12'h020, 32'hAABBCCDD, 4'b0101);
        chk("strobe", ptrs[31:0], 32'h11BB33DD);
        rd(12'h020, rv); chk("strobe_rd", rv, 32'h11BB33DD);

        awvalid = 1'b1; awaddr = 12'h010;
        step();
        awvalid = 1'b0; wvalid = 1'b1; wdata = 32'hCAFE0001; wstrb = 4'hF;
        chk("lat_wready", wready, 1);
        chk("lat_pre", scalars[31:0], 0);
        step();
        chk("lat_post", scalars[31:0], 32'hCAFE0001);
        chk("lat_bvalid", bvalid, 1);
        wvalid = 1'b0; bready = 1'b1;
        step();
        bready = 1'b0;
        chk("lat_bdone", bvalid, 0);

        wr(12'h000, 32'h1, 4'h1);
        chk("start_set", ap_start, 1);
        pulse_ready();
        chk("start_clr", ap_start, 0);
        rd(12'h000, rv); chk("ctrl_rdy1", rv, 32'hC);
        rd(12'h000, rv); chk("ctrl_rdy0", rv, 32'h4);

        wr(12'h000, 32'h81, 4'h1);
        chk("auto_start", ap_start, 1);
        pulse_ready();
        chk("auto_rdy", ap_start, 0);
        pulse_done();
        chk("auto_restart", ap_start, 1);
        rd(12'h000, rv); chk("auto_ctrl", rv, 32'h8F);
        wr(12'h000, 32'h0, 4'h1);
        chk("write0_keep", ap_start, 1);
        rd(12'h000, rv); chk("auto_off", rv, 32'h5);
        pulse_ready();
        chk("auto_off_clr", ap_start, 0);

        wr(12'h000, 32'h1, 4'h1);
        aclk_en = 1'b0; ap_ready = 1'b1;
        step();
        aclk_en = 1'b1; ap_ready = 1'b0;
        chk("en_freeze", ap_start, 1);
        pulse_ready();
        chk("en_resume", ap_start, 0);

        wr(12'h004, 32'h1, 4'h1);
        wr(12'h008, 32'h3, 4'h1);
        chk("irq_idle", interrupt, 0);
        pulse_done();
        chk("irq_done", interrupt, 1);
        rd(12'h00C, rv); chk("isr_done", rv, 32'h1);
        wr(12'h00C, 32'h1, 4'h1);
        rd(12'h00C, rv); chk("isr_clr", rv, 0);
        chk("irq_clr", interrupt, 0);
        pulse_ready();
        rd(12'h00C, rv); chk("isr_ready", rv, 32'h2);
        wr(12'h004, 32'h0, 4'b1110);
        chk("gie_nostrb", interrupt, 1);
        wr(12'h00C, 32'h2, 4'h1);
        chk("irq_rdy_clr", interrupt, 0);

        pulse_done();
        awvalid = 1'b1; awaddr = 12'h00C;
        step();
        awvalid = 1'b0; wvalid = 1'b1; wdata = 32'h1; wstrb = 4'h1;
        ap_done = 1'b1;
        step();
        ap_done = 1'b0; wvalid = 1'b0; bready = 1'b1;
        step();
        bready = 1'b0;
        rd(12'h00C, rv); chk("isr_set_wins", rv, 32'h1);

        rd(12'h000, rv);
        arvalid = 1'b1; araddr = 12'h000; ap_done = 1'b1;
        step();
        arvalid = 1'b0; ap_done = 1'b0; rready = 1'b1;
        chk("cor_pre", rdata[1], 0);
        step();
        rready = 1'b0;
        rd(12'h000, rv); chk("cor_kept", rv[1], 1);

        arvalid = 1'b1; araddr = 12'h018;
        step();
        arvalid = 1'b0;
        chk("mid_rvalid", rvalid, 1);
        areset = 1'b1;
        step();
        areset = 1'b0;
        chk("mid_rst_rvalid", rvalid, 0);
        chk("mid_rst_scalars", scalars, 0);
        chk("mid_rst_irq", {interrupt, ap_start}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/kernel_ctrl_s_axi_n.md
# kernel_ctrl_s_axi_n

Parametrised AXI4-Lite control slave for the kernel family: `ap_ctrl` block plus a configurable number of 32-bit scalar arguments and 64-bit buffer pointers. It sits between the host shell's AXI4-Lite control port and the kernel datapath. It generalises the fixed-argument control slave with:
- parametrised argument counts;
- an `ap_ready` handshake;
- auto-restart mode;
- a two-source interrupt (done, ready).

## Interface
Parameters:
- C_ADDR_WIDTH, 12, AXI4-Lite address width.
- C_DATA_WIDTH, 32, data width; fixed at 32, other values unsupported.
- C_NUM_SCALARS, 1, number of 32-bit scalar args (1–16).
- C_NUM_PTRS, 2, number of 64-bit pointer args (1–16).

Ports:
- aclk  in  1  clock; one clock domain.
- areset  in  1  synchronous, active-high reset.
- aclk_en  in  1  clock enable; when low, all state holds.
- awvalid/awready/awaddr, wvalid/wready/wdata/wstrb(4), bvalid/bready/bresp(2): AXI4-Lite write channels.
- arvalid/arready/araddr, rvalid/rready/rdata/rresp(2): AXI4-Lite read channels.
- interrupt  out  1  level interrupt.
- ap_start  out  1  start request to the kernel.
- ap_idle, ap_done, ap_ready  in  1 each  kernel status; ap_done and ap_ready are single-cycle pulses.
- scalars  out  32*C_NUM_SCALARS  scalar i is at bits [32i+31:32i].
- ptrs  out  64*C_NUM_PTRS  pointer j is at bits [64j+63:64j].

## Operation
Address map (byte addresses):
- 0x00 CTRL:
  - bit0 ap_start (RW; write-1 sets, writing 0 has no effect).
  - bit1 ap_done (COR).
  - bit2 ap_idle (RO, live).
  - bit3 ap_ready (COR).
  - bit7 auto_restart (RW).
- 0x04 GIE: bit0.
- 0x08 IER: bit0 done, bit1 ready.
- 0x0C ISR: bit0 done, bit1 ready; toggle-on-write.
- Scalar i: 0x10+8i. The upper word at 0x14+8i is reserved.
- Pointer j: base P = 0x10+8*C_NUM_SCALARS, low word at P+8j, high word at P+8j+4.
- Unmapped/reserved addresses: reads return 0; writes are ignored; response is always OKAY.

Write FSM:
- States WRRESET → WRIDLE → WRDATA → WRRESP.
- WRIDLE→WRDATA on awvalid, latching awaddr.
- WRDATA→WRRESP on wvalid; the register update happens on that edge.
- WRRESP→WRIDLE on bready.
- awready is high only in WRIDLE, wready only in WRDATA, bvalid only in WRRESP.

Read FSM:
- States RDRESET → RDIDLE → RDDATA.
- RDIDLE→RDDATA on arvalid; araddr is decoded and rdata registered on the same edge.
- RDDATA→RDIDLE on rready.

Register rules:
- Argument writes are byte-masked by wstrb.
- CTRL/GIE/IER/ISR writes take effect only if wstrb[0] is set.

Register behaviour:
- ap_start:
  - Set by a CTRL write with bit0 = 1.
  - Cleared by ap_ready.
  - If auto_restart = 1, ap_done re-sets it.
  - Write and ap_ready in the same cycle: the set wins.
- ap_done / ap_ready status bits:
  - Set by the matching input pulse.
  - Cleared on a CTRL read handshake.
  - Pulse and read in the same cycle: the bit ends at 1, and the read returns the pre-edge value.
- ISR[k]:
  - Set by its source pulse when IER[k] = 1.
  - Otherwise toggled by wdata[k] on an ISR write.
  - Source pulse and write in the same cycle: the set wins.
- interrupt = GIE & |(ISR & IER-independent ISR bits) = GIE & (ISR[0] | ISR[1]).

## Timing
- Reset values: all registers, arguments, ap_start, interrupt, bvalid, rvalid and rdata are 0.
- During reset and for the first enabled cycle after it, awready = arready = 0. Both are 1 from the second enabled cycle.
- Write latency: awaddr handshake at edge N, wready at N+1. If wvalid is present, the register and its output port update at edge N+1. bvalid is asserted in cycle N+2.
- Read latency: ar handshake at edge N; rvalid and rdata are valid from cycle N+1 and held until rready.
- One outstanding transaction per direction. Reads and writes proceed independently and may overlap.
- aclk_en = 0 freezes the FSMs and every register; input pulses arriving in that cycle are lost.
- areset mid-transaction: both FSMs return to their RESET states, bvalid/rvalid drop the next cycle, and all registers clear.

## Test plan
- Reset then idle → awready/arready = 0 for 1 cycle, then 1. All outputs 0. A CTRL read returns 0x4 when ap_idle = 1.
- With C_NUM_SCALARS=2, C_NUM_PTRS=2:
  - Write 0xDEADBEEF to 0x18 → scalars[63:32] = 0xDEADBEEF.
  - Write 0x1 to 0x2C → ptrs[127:96] = 1.
  - Read 0x14 → 0.
- Partial strobe: ptr0-low holds 0x11223344; write 0xAABBCCDD with wstrb = 0b0101 → 0x11BB33DD.
- Start handshake:
  - Write CTRL = 1 → ap_start = 1 next cycle.
  - ap_ready pulse → ap_start = 0.
  - CTRL read returns bit3 = 1; a second read returns bit3 = 0.
- Auto-restart: CTRL = 0x81, then ap_ready followed by ap_done → ap_start re-asserts the cycle after ap_done; the done bit is set.
- Interrupt, with GIE=1, IER=0x3:
  - ap_done → interrupt = 1, ISR = 0x1.
  - Write ISR = 0x1 → ISR = 0, interrupt = 0.
  - ap_done plus an ISR write in the same cycle → ISR[0] = 1.
